// File: rtl/run_sequencer.sv
// run_sequencer: req/ack run controller that holds the core in init, runs it to the halt PC and
// counts RUN cycles, aborting runaway programs through a watchdog.
module run_sequencer #(
    parameter int             A           = 16,
    parameter logic [A-1:0]   HALT_PC     = 'h1FF,
    parameter int             INIT_CYCLES = 2,
    parameter int             CW          = 16,
    parameter int             TIMEOUT     = 'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [A-1:0]  pc,
    output logic          ack,
    output logic          core_init,
    output logic          core_run,
    output logic          busy,
    output logic [CW-1:0] cycle_count,
    output logic          timeout_flag
);
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
    localparam int             IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0]  INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0]  RUN_LAST  = CW'(TIMEOUT - 1);
    state_t        state;
    logic [IW-1:0] init_cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            init_cnt     <= '0;
            cycle_count  <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state        <= INIT;
                    init_cnt     <= INIT_LAST;
                    cycle_count  <= '0;
                    timeout_flag <= 1'b0;
                end
                INIT: begin
                    init_cnt <= init_cnt - IW'(1);
                    if (init_cnt == '0) state <= RUN;
                end
                RUN: begin
                    // saturate rather than wrap when the watchdog is disabled
                    if (cycle_count != '1) cycle_count <= cycle_count + CW'(1);
                    if (pc == HALT_PC) begin
                        state        <= DONE;
                        timeout_flag <= 1'b0;
                    end else if (TIMEOUT != 0 && cycle_count == RUN_LAST) begin
                        state        <= DONE;
                        timeout_flag <= 1'b1;
                    end
                end
                DONE: if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign ack       = (state == DONE);
    assign core_init = (state == IDLE) || (state == INIT);
    assign core_run  = (state == RUN);
    assign busy      = (state == INIT) || (state == RUN);
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: randomized programs against a halt/timeout reference model.
module tb_run_sequencer;
    localparam int            T       = 20;
    localparam logic [15:0]   HALT    = 16'h1FF;
    localparam int            NINIT   = 2;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [15:0] pc = '0;
    logic        ack, core_init, core_run, busy, timeout_flag;
    logic [15:0] cycle_count;
    int          total = 0;
    int          bad = 0;
    run_sequencer #(.A(16), .HALT_PC(HALT), .INIT_CYCLES(NINIT), .CW(16), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .pc(pc), .ack(ack), .core_init(core_init),
        .core_run(core_run), .busy(busy), .cycle_count(cycle_count), .timeout_flag(timeout_flag)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] other_pc();
        return 16'($urandom_range(0, 'h1FE));
    endfunction
    // h: RUN cycle on which pc shows HALT (0 = never); hold: DONE cycles with req kept high;
    // rst_at: RUN cycle on which reset is asserted (0 = none)
    task automatic run_program(input int h, input int hold, input int rst_at);
        int exp_cycles, n, r;
        logic exp_tf;
        exp_cycles = (h != 0 && h <= T) ? h : T;
        exp_tf     = !(h != 0 && h <= T);
        check("idle_ack", ack, 0);
        check("idle_init", core_init, 1);
        req = 1'b1;
        pc  = other_pc();
        tick();
        check("init_busy", busy, 1);
        check("init_run", core_run, 0);
        check("init_clr_cnt", cycle_count, 0);
        check("init_clr_tf", timeout_flag, 0);
        n = 0;
        while (core_init === 1'b1 && n < 50) begin
            n++;
            req = (hold > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        check("init_len", n, NINIT);
        check("run_start", core_run, 1);
        r = 0;
        do begin
            r++;
            pc = (r == h) ? HALT : other_pc();
            req = (r < exp_cycles) ? 1'($urandom_range(0, 1)) : (hold > 0);
            if (r == rst_at) begin
                check("pre_rst_cnt", cycle_count, r - 1);
                reset = 1'b0;
                req = 1'b0;
                tick();
                check("rst_ack", ack, 0);
                check("rst_init", core_init, 1);
                check("rst_run", core_run, 0);
                check("rst_cnt", cycle_count, 0);
                reset = 1'b1;
                tick();
                check("rst_idle_ack", ack, 0);
                return;
            end
            tick();
        end while (core_run === 1'b1 && r < 200);
        check("run_len", r, exp_cycles);
        check("done_ack", ack, 1);
        check("done_cnt", cycle_count, exp_cycles);
        check("done_tf", timeout_flag, exp_tf);
        check("done_init", core_init, 0);
        check("done_busy", busy, 0);
        for (int i = 1; i < hold; i++) begin
            tick();
            check("hold_ack", ack, 1);
            check("hold_run", core_run, 0);
        end
        req = 1'b0;
        tick();
        check("idle_ack_drop", ack, 0);
        check("idle_cnt_kept", cycle_count, exp_cycles);
        check("idle_tf_kept", timeout_flag, exp_tf);
    endtask
    initial begin
        req = 1'b1;
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_init", core_init, 1);
        check("rst_run", core_run, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cycle_count, 0);
        check("rst_tf", timeout_flag, 0);
        reset = 1'b1;
        req = 1'b0;
        tick();
        check("idle_after_rst", ack, 0);
        run_program(10, 0, 0);
        run_program(0, 0, 0);
        run_program(T, 0, 0);
        run_program(1, 0, 0);
        run_program(12, 5, 0);
        run_program(3, 0, 0);
        run_program(0, 0, 7);
        for (int k = 0; k < 25; k++)
            run_program($urandom_range(0, T + 5), $urandom_range(0, 4), ($urandom_range(0, 5) == 0) ? 7 : 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
